// File: rtl/lsu_access_sequencer.sv
// lsu_access_sequencer: data memory initiator for the MEM stage.
// Splits misaligned half/word accesses into byte beats.
package lsu_pkg;
  localparam logic [2:0] MEM_BYTE              = 3'b000;
  localparam logic [2:0] MEM_HALFWORD          = 3'b001;
  localparam logic [2:0] MEM_WORD              = 3'b010;
  localparam logic [2:0] MEM_BYTE_UNSIGNED     = 3'b100;
  localparam logic [2:0] MEM_HALFWORD_UNSIGNED = 3'b101;
endpackage

module lsu_access_sequencer
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_W_En,
  input  logic [2:0]  Req_Control,
  input  logic [31:0] Req_Addr,
  input  logic [31:0] Req_W_Data,
  output logic        Busy,
  output logic        Resp_Valid,
  output logic        Resp_Fault,
  output logic [31:0] Load_Data,
  output logic        MEM_W_En,
  output logic [2:0]  MEM_Control,
  output logic [31:0] RW_Addr,
  output logic [31:0] W_Data,
  input  logic [31:0] R_Data
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  state_t      state, state_next;
  logic [2:0]  ctl, ctl_next;
  logic [31:0] addr, addr_next;
  logic [31:0] wdata, wdata_next;
  logic [31:0] buffer, buffer_next;
  logic        wen, wen_next;
  logic        split, split_next;
  logic [1:0]  beat, beat_next;

  logic        fault_next;
  logic [31:0] load_next;
  logic        mem_we_next;
  logic [2:0]  mem_ctl_next;
  logic [31:0] rw_addr_next;
  logic [31:0] w_data_next;

  logic [2:0]  req_size;
  logic [32:0] req_last;
  logic        req_fault;
  logic        req_split;
  logic        last_beat;

  // Split halfword results need extension; word and aligned results are final.
  function automatic logic [31:0] extend(
    input logic [2:0]  c,
    input logic        s,
    input logic [31:0] b
  );
    logic [31:0] r;
    r = b;
    if (s) begin
      if (c == MEM_HALFWORD)
        r = {{16{b[15]}}, b[15:0]};
      else if (c == MEM_HALFWORD_UNSIGNED)
        r = {16'h0000, b[15:0]};
    end
    return r;
  endfunction

  // Decode the access width of the incoming request; zero marks a bad code.
  always_comb begin
    req_size = 3'd0;
    unique case (Req_Control)
      MEM_BYTE, MEM_BYTE_UNSIGNED:         req_size = 3'd1;
      MEM_HALFWORD, MEM_HALFWORD_UNSIGNED: req_size = 3'd2;
      MEM_WORD:                            req_size = 3'd4;
      default:                             req_size = 3'd0;
    endcase
  end

  // Range, wrap and encoding checks plus the misalignment decision.
  always_comb begin
    req_last  = {1'b0, Req_Addr} + {30'b0, req_size} - 33'd1;
    req_fault = (req_size == 3'd0) || req_last[32] ||
                (req_last >= 33'(MEM_BYTES));
    req_split = ((req_size == 3'd2) && Req_Addr[0]) ||
                ((req_size == 3'd4) && (Req_Addr[1:0] != 2'b00));
    last_beat = !split ||
                (beat == ((ctl == MEM_WORD) ? 2'd3 : 2'd1));
  end

  // Next state, latched request and the registered memory-port values.
  always_comb begin
    state_next   = state;
    ctl_next     = ctl;
    addr_next    = addr;
    wdata_next   = wdata;
    wen_next     = wen;
    split_next   = split;
    beat_next    = beat;
    buffer_next  = buffer;
    fault_next   = 1'b0;
    load_next    = Load_Data;
    mem_we_next  = 1'b0;
    mem_ctl_next = MEM_Control;
    rw_addr_next = RW_Addr;
    w_data_next  = W_Data;
    unique case (state)
      IDLE: begin
        if (Req_Valid) begin
          ctl_next    = Req_Control;
          addr_next   = Req_Addr;
          wdata_next  = Req_W_Data;
          wen_next    = Req_W_En;
          split_next  = req_split;
          beat_next   = 2'd0;
          buffer_next = 32'h0;
          if (req_fault) begin
            state_next = RESP;
            fault_next = 1'b1;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (wen) begin
          if (last_beat)
            state_next = RESP;
          else
            beat_next = beat + 2'd1;
        end else begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (split)
          buffer_next[{beat, 3'b000} +: 8] = R_Data[7:0];
        else
          buffer_next = R_Data;
        if (last_beat) begin
          state_next = RESP;
          load_next  = extend(ctl, split, buffer_next);
        end else begin
          beat_next  = beat + 2'd1;
          state_next = ISSUE;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
    endcase
    // Port values are set up for the beat being entered so they are
    // already on the pins during the ISSUE cycle.
    if (state_next == ISSUE) begin
      mem_we_next  = wen_next;
      mem_ctl_next = split_next ? MEM_BYTE_UNSIGNED : ctl_next;
      rw_addr_next = addr_next + {30'b0, beat_next};
      w_data_next  = split_next ?
        {24'h0, wdata_next[{beat_next, 3'b000} +: 8]} : wdata_next;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Request latch, load buffer and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ctl         <= MEM_WORD;
      addr        <= 32'h0;
      wdata       <= 32'h0;
      wen         <= 1'b0;
      split       <= 1'b0;
      beat        <= 2'd0;
      buffer      <= 32'h0;
      Req_Ready   <= 1'b1;
      Busy        <= 1'b0;
      Resp_Valid  <= 1'b0;
      Resp_Fault  <= 1'b0;
      Load_Data   <= 32'h0;
      MEM_W_En    <= 1'b0;
      MEM_Control <= MEM_WORD;
      RW_Addr     <= 32'h0;
      W_Data      <= 32'h0;
    end else begin
      ctl         <= ctl_next;
      addr        <= addr_next;
      wdata       <= wdata_next;
      wen         <= wen_next;
      split       <= split_next;
      beat        <= beat_next;
      buffer      <= buffer_next;
      Req_Ready   <= (state_next == IDLE);
      Busy        <= (state_next != IDLE);
      Resp_Valid  <= (state_next == RESP);
      Resp_Fault  <= fault_next;
      Load_Data   <= load_next;
      MEM_W_En    <= mem_we_next;
      MEM_Control <= mem_ctl_next;
      RW_Addr     <= rw_addr_next;
      W_Data      <= w_data_next;
    end
  end

endmodule

// File: tb/tb_lsu_access_sequencer.sv
// tb_lsu_access_sequencer: bench for the data memory sequencer.
// Byte-array memory plus a byte-level reference of expected contents.
module tb_lsu_access_sequencer;

  localparam int unsigned MB = 256;
  localparam logic [2:0] C_B  = 3'b000;
  localparam logic [2:0] C_H  = 3'b001;
  localparam logic [2:0] C_W  = 3'b010;
  localparam logic [2:0] C_BU = 3'b100;
  localparam logic [2:0] C_HU = 3'b101;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Req_Valid;
  logic        Req_Ready;
  logic        Req_W_En;
  logic [2:0]  Req_Control;
  logic [31:0] Req_Addr;
  logic [31:0] Req_W_Data;
  logic        Busy;
  logic        Resp_Valid;
  logic        Resp_Fault;
  logic [31:0] Load_Data;
  logic        MEM_W_En;
  logic [2:0]  MEM_Control;
  logic [31:0] RW_Addr;
  logic [31:0] W_Data;
  logic [31:0] R_Data;

  always #5 CLK = ~CLK;

  lsu_access_sequencer #(.MEM_BYTES(MB)) dut (
    .CLK(CLK), .RST(RST),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Req_W_En(Req_W_En), .Req_Control(Req_Control),
    .Req_Addr(Req_Addr), .Req_W_Data(Req_W_Data),
    .Busy(Busy), .Resp_Valid(Resp_Valid),
    .Resp_Fault(Resp_Fault), .Load_Data(Load_Data),
    .MEM_W_En(MEM_W_En), .MEM_Control(MEM_Control),
    .RW_Addr(RW_Addr), .W_Data(W_Data), .R_Data(R_Data)
  );

  logic [7:0]  mem [0:255];
  logic [7:0]  ref_mem [0:255];
  logic [31:0] rd_q = 32'h0;
  logic [31:0] wl_addr [$];
  logic [2:0]  wl_ctl [$];
  logic [31:0] wl_data [$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_load = 32'h0;

  assign R_Data = rd_q;

  function automatic int sz(input logic [2:0] c);
    case (c)
      C_B, C_BU: return 1;
      C_H, C_HU: return 2;
      C_W:       return 4;
      default:   return 0;
    endcase
  endfunction

  function automatic bit is_signed(input logic [2:0] c);
    return (c == C_B) || (c == C_H);
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a,
                                           input logic [2:0] c);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = sz(c);
    for (int k = 0; k < n; k++)
      v[8*k +: 8] = mem[8'(a + 32'(k))];
    if (is_signed(c) && n < 4 && v[8*n-1])
      v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a,
                                           input logic [2:0] c);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = sz(c);
    for (int k = 0; k < n; k++)
      v[8*k +: 8] = ref_mem[8'(a + 32'(k))];
    if (is_signed(c) && n < 4 && v[8*n-1])
      v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  function automatic bit ref_fault(input logic [2:0] c,
                                   input logic [31:0] a);
    return (sz(c) == 0) || (longint'(a) + sz(c) - 1 >= longint'(MB));
  endfunction

  function automatic int ref_beats(input logic [2:0] c,
                                   input logic [31:0] a);
    int n;
    n = sz(c);
    return (n > 1 && (a % n) != 0) ? n : 1;
  endfunction

  function automatic int ref_lat(input bit w, input logic [2:0] c,
                                 input logic [31:0] a);
    if (ref_fault(c, a)) return 1;
    return w ? ref_beats(c, a) + 1 : 2 * ref_beats(c, a) + 1;
  endfunction

  // Memory model: write on posedge, read data ready the next cycle.
  always @(posedge CLK) begin
    if (MEM_W_En) begin
      for (int k = 0; k < sz(MEM_Control); k++)
        mem[8'(RW_Addr + 32'(k))] <= W_Data[8*k +: 8];
      wl_addr.push_back(RW_Addr);
      wl_ctl.push_back(MEM_Control);
      wl_data.push_back(W_Data);
    end
    rd_q <= mem_read(RW_Addr, MEM_Control);
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wl_addr.delete();
    wl_ctl.delete();
    wl_data.delete();
  endtask

  task automatic do_req(input bit w, input logic [2:0] c,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] got);
    int n, beats, lat, elat, ew, tries;
    bit f, mis;
    logic [31:0] eld;
    n     = sz(c);
    f     = ref_fault(c, a);
    beats = ref_beats(c, a);
    mis   = beats > 1;
    elat  = ref_lat(w, c, a);
    eld   = (w || f) ? last_load : ref_load(a, c);
    tries = 0;
    while (!Req_Ready && tries < 20) begin
      @(negedge CLK);
      tries++;
    end
    check("req_ready", 32'(Req_Ready), 32'd1);
    clear_log();
    Req_Valid   = 1'b1;
    Req_W_En    = w;
    Req_Control = c;
    Req_Addr    = a;
    Req_W_Data  = d;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
      if (lat == 1) Req_Valid = 1'b0;
    end while (!Resp_Valid && lat < 20);
    check("latency", 32'(lat), 32'(elat));
    check("resp_fault", 32'(Resp_Fault), 32'(f));
    if (!f)
      check("load_data", Load_Data, eld);
    got = Load_Data;
    ew = (w && !f) ? beats : 0;
    check("write_count", 32'(wl_addr.size()), 32'(ew));
    if (ew > 0 && wl_addr.size() == ew) begin
      for (int k = 0; k < ew; k++) begin
        check("w_addr", wl_addr[k], mis ? a + 32'(k) : a);
        check("w_ctl", 32'(wl_ctl[k]), 32'(mis ? C_BU : c));
        check("w_data", wl_data[k],
              mis ? {24'h0, d[8*k +: 8]} : d);
      end
    end
    if (ew > 0) begin
      for (int k = 0; k < n; k++) begin
        ref_mem[8'(a + 32'(k))] = d[8*k +: 8];
        check("mem_byte", 32'(mem[8'(a + 32'(k))]),
              32'(ref_mem[8'(a + 32'(k))]));
      end
    end
    if (!w && !f) last_load = eld;
    @(negedge CLK);
    check("resp_pulse", 32'(Resp_Valid), 32'd0);
    check("idle_busy", 32'(Busy), 32'd0);
  endtask

  logic [2:0] codes [7] = '{C_B, C_H, C_W, C_BU, C_HU, 3'b011, 3'b111};

  initial begin
    logic [31:0] got, d;
    logic [15:0] rv_seen, rd_seen, rv_exp, rd_exp;
    int phase, la, lb, rvcount;
    logic [31:0] bdata;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    RST = 1'b1;
    Req_Valid = 1'b0;
    Req_W_En = 1'b0;
    Req_Control = C_W;
    Req_Addr = 32'h0;
    Req_W_Data = 32'h0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_ready", 32'(Req_Ready), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_resp_valid", 32'(Resp_Valid), 32'd0);
    check("rst_resp_fault", 32'(Resp_Fault), 32'd0);
    check("rst_load_data", Load_Data, 32'h0);
    check("rst_mem_w_en", 32'(MEM_W_En), 32'd0);
    check("rst_mem_ctl", 32'(MEM_Control), 32'(C_W));
    check("rst_rw_addr", RW_Addr, 32'h0);
    check("rst_w_data", W_Data, 32'h0);

    do_req(1'b1, C_W, 32'h04, 32'hFBBF_FAAF, got);
    do_req(1'b0, C_W, 32'h04, 32'h0, got);
    check("plan_word_load", got, 32'hFBBF_FAAF);
    do_req(1'b1, C_W, 32'h05, 32'h8877_6655, got);
    do_req(1'b0, C_W, 32'h05, 32'h0, got);
    check("plan_split_word", got, 32'h8877_6655);
    do_req(1'b1, C_H, 32'h03, 32'h0000_F00F, got);
    do_req(1'b0, C_H, 32'h03, 32'h0, got);
    check("plan_split_h", got, 32'hFFFF_F00F);
    do_req(1'b0, C_HU, 32'h03, 32'h0, got);
    check("plan_split_hu", got, 32'h0000_F00F);
    do_req(1'b0, C_BU, 32'h04, 32'h0, got);
    check("plan_byte", got, 32'h0000_00F0);
    do_req(1'b0, C_W, 32'hFE, 32'h0, got);
    do_req(1'b0, C_W, 32'hFFFF_FFFF, 32'h0, got);
    do_req(1'b0, 3'b011, 32'h00, 32'h0, got);
    do_req(1'b1, C_W, 32'hFD, 32'h1234_5678, got);

    // Reset in the middle of a split word store.
    d = 32'hCAFE_BABE;
    clear_log();
    Req_Valid = 1'b1;
    Req_W_En = 1'b1;
    Req_Control = C_W;
    Req_Addr = 32'h11;
    Req_W_Data = d;
    @(negedge CLK);
    Req_Valid = 1'b0;
    repeat (2) @(negedge CLK);
    check("mid_rw_addr", RW_Addr, 32'h13);
    check("mid_w_data", W_Data, {24'h0, d[23:16]});
    check("mid_w_en", 32'(MEM_W_En), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("rst_mid_writes", 32'(wl_addr.size()), 32'd3);
    check("rst_mid_w_en", 32'(MEM_W_En), 32'd0);
    check("rst_mid_busy", 32'(Busy), 32'd0);
    check("rst_mid_ready", 32'(Req_Ready), 32'd1);
    for (int k = 0; k < 3; k++)
      ref_mem[8'(32'h11 + 32'(k))] = d[8*k +: 8];
    clear_log();
    rvcount = 0;
    repeat (6) begin
      @(negedge CLK);
      rvcount += int'(Resp_Valid);
    end
    check("rst_no_writes", 32'(wl_addr.size()), 32'd0);
    check("rst_no_resp", 32'(rvcount), 32'd0);
    do_req(1'b0, C_W, 32'h10, 32'h0, got);

    // Back-to-back with Req_Valid held across the first response.
    la = ref_lat(1'b1, C_W, 32'h20);
    lb = ref_lat(1'b0, C_W, 32'h20);
    clear_log();
    Req_Valid = 1'b1;
    Req_W_En = 1'b1;
    Req_Control = C_W;
    Req_Addr = 32'h20;
    Req_W_Data = 32'h1234_5678;
    phase = 0;
    bdata = 32'h0;
    rv_seen = 16'h0;
    rd_seen = 16'h0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      if (phase == 2) begin
        Req_Valid = 1'b0;
        phase = 3;
      end
      rv_seen[i] = Resp_Valid;
      rd_seen[i] = Req_Ready;
      if (Resp_Valid && phase == 0) begin
        for (int k = 0; k < 4; k++)
          ref_mem[8'(32'h20 + 32'(k))] = Req_W_Data[8*k +: 8];
        Req_W_En = 1'b0;
        phase = 1;
      end else if (phase == 1 && Req_Ready) begin
        phase = 2;
      end
      if (Resp_Valid && phase == 3) bdata = Load_Data;
    end
    rv_exp = 16'h0;
    rd_exp = 16'h0;
    for (int i = 1; i <= 10; i++) begin
      rv_exp[i] = (i == la) || (i == la + 1 + lb);
      rd_exp[i] = (i == la + 1) || (i > la + 1 + lb);
    end
    check("b2b_resp", 32'(rv_seen), 32'(rv_exp));
    check("b2b_ready", 32'(rd_seen), 32'(rd_exp));
    check("b2b_data", bdata, ref_load(32'h20, C_W));
    check("b2b_writes", 32'(wl_addr.size()), 32'd1);
    last_load = ref_load(32'h20, C_W);
    Req_Valid = 1'b0;

    // Randomized requests against the reference.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      logic [2:0] c;
      c = codes[$urandom_range(0, 6)];
      if ($urandom_range(0, 4) == 0)
        a = ($urandom_range(0, 1) == 0) ?
            32'($urandom_range(240, 300)) :
            32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else
        a = 32'($urandom_range(0, 255));
      do_req(1'($urandom_range(0, 1)), c, a, $urandom, got);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
